// File: rtl/simon_stream_ctrl.sv
// Stream-to-register sequencer for the memory-mapped Simon 128/128 interface.
// Optional performance counters are built when SIMON_STREAM_PERF_EN is defined.
module simon_stream_ctrl #(
  parameter int READ_LAT     = 1,
  parameter int POLL_TIMEOUT = 1023
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_i,
  input  logic         key_load_i,
  input  logic         mode_i,
  input  logic         s_valid_i,
  output logic         s_ready_o,
  input  logic [127:0] s_data_i,
  output logic         m_valid_o,
  input  logic         m_ready_i,
  output logic [127:0] m_data_o,
  output logic         busy_o,
  output logic         err_timeout_o,
  output logic         bus_en_o,
  output logic [3:0]   bus_we_o,
  output logic [7:0]   bus_addr_o,
  output logic [31:0]  bus_wdata_o,
  input  logic [31:0]  bus_rdata_i
`ifdef SIMON_STREAM_PERF_EN
  ,
  output logic [15:0]  blk_cnt_o,
  output logic [15:0]  last_lat_o
`endif
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_KEY_WR  = 4'd1;
  localparam logic [3:0] S_MODE_WR = 4'd2;
  localparam logic [3:0] S_PT_WR   = 4'd3;
  localparam logic [3:0] S_START   = 4'd4;
  localparam logic [3:0] S_POLL    = 4'd5;
  localparam logic [3:0] S_CT_RD   = 4'd6;
  localparam logic [3:0] S_OUT     = 4'd7;
  localparam logic [3:0] S_ERR     = 4'd8;

  localparam logic [7:0] ADDR_CSR  = 8'h30;
  localparam logic [7:0] ADDR_MODE = 8'h34;

  localparam logic [1:0] HOLD_LAST   = 2'(READ_LAT);
  localparam logic [9:0] POLL_SETTLE = 10'(READ_LAT);
  localparam logic [9:0] POLL_LAST   = 10'(POLL_TIMEOUT);

  logic [3:0]   state;
  logic [3:0]   state_nxt;
  logic [1:0]   beat_cnt;
  logic [1:0]   hold_cnt;
  logic [9:0]   poll_cnt;
  logic         s_ready_q;
  logic         err_q;
  logic         key_dirty;
  logic         mode_known;
  logic         mode_cur;
  logic         mode_blk;
  logic [127:0] key_q;
  logic [127:0] key_blk;
  logic [127:0] pt_q;
  logic [127:0] ct_q;
  logic         accept;
  logic         mode_change;
  logic         poll_done;
  logic         hold_done;

  assign accept      = s_valid_i && s_ready_q;
  assign mode_change = !mode_known || (mode_i != mode_cur);
  assign poll_done   = (poll_cnt >= POLL_SETTLE) && bus_rdata_i[1];
  assign hold_done   = (hold_cnt == HOLD_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (key_dirty)        state_nxt = S_KEY_WR;
          else if (mode_change) state_nxt = S_MODE_WR;
          else                  state_nxt = S_PT_WR;
        end
      end
      // A freshly written key always forces a MODE write behind it.
      S_KEY_WR:  if (beat_cnt == 2'd3) state_nxt = S_MODE_WR;
      S_MODE_WR: state_nxt = S_PT_WR;
      S_PT_WR:   if (beat_cnt == 2'd3) state_nxt = S_START;
      S_START:   state_nxt = S_POLL;
      S_POLL: begin
        if (poll_done)                  state_nxt = S_CT_RD;
        else if (poll_cnt == POLL_LAST) state_nxt = S_ERR;
      end
      S_CT_RD:   if (beat_cnt == 2'd3 && hold_done) state_nxt = S_OUT;
      S_OUT:     if (m_ready_i) state_nxt = S_IDLE;
      S_ERR:     state_nxt = S_ERR;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // ---- control registers: state, counters, flags ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      beat_cnt   <= 2'd0;
      hold_cnt   <= 2'd0;
      poll_cnt   <= 10'd0;
      s_ready_q  <= 1'b0;
      err_q      <= 1'b0;
      key_dirty  <= 1'b1;
      mode_known <= 1'b0;
      mode_cur   <= 1'b0;
    end else begin
      state     <= state_nxt;
      s_ready_q <= (state_nxt == S_IDLE);
      if (state_nxt == S_ERR) err_q <= 1'b1;

      if (state_nxt != state) begin
        beat_cnt <= 2'd0;
        hold_cnt <= 2'd0;
        poll_cnt <= 10'd0;
      end else begin
        case (state)
          S_KEY_WR, S_PT_WR: beat_cnt <= beat_cnt + 2'd1;
          S_POLL:            poll_cnt <= poll_cnt + 10'd1;
          S_CT_RD: begin
            if (hold_done) begin
              hold_cnt <= 2'd0;
              beat_cnt <= beat_cnt + 2'd1;
            end else begin
              hold_cnt <= hold_cnt + 2'd1;
            end
          end
          default: ;
        endcase
      end

      // A load during a transfer re-marks the key; it only lands on the next block.
      if (key_load_i)  key_dirty <= 1'b1;
      else if (accept) key_dirty <= 1'b0;

      if (state == S_MODE_WR) begin
        mode_cur   <= mode_blk;
        mode_known <= 1'b1;
      end
    end
  end

  // ---- data registers: key snapshot, block, readback ----
  always_ff @(posedge clk) begin
    if (key_load_i) key_q <= key_i;
    if (accept) begin
      key_blk  <= key_q;
      pt_q     <= s_data_i;
      mode_blk <= mode_i;
    end
    if (state == S_CT_RD && hold_done) ct_q[{beat_cnt, 5'b0} +: 32] <= bus_rdata_i;
  end

  always_comb begin
    bus_en_o    = 1'b0;
    bus_we_o    = 4'b0000;
    bus_addr_o  = 8'h00;
    bus_wdata_o = 32'h0;
    case (state)
      S_KEY_WR: begin
        bus_en_o    = 1'b1;
        bus_we_o    = 4'b1111;
        bus_addr_o  = {4'h1, beat_cnt, 2'b00};
        bus_wdata_o = key_blk[{beat_cnt, 5'b0} +: 32];
      end
      S_MODE_WR: begin
        bus_en_o    = 1'b1;
        bus_we_o    = 4'b1111;
        bus_addr_o  = ADDR_MODE;
        bus_wdata_o = {31'h0, mode_blk};
      end
      S_PT_WR: begin
        bus_en_o    = 1'b1;
        bus_we_o    = 4'b1111;
        bus_addr_o  = {4'h0, beat_cnt, 2'b00};
        bus_wdata_o = pt_q[{beat_cnt, 5'b0} +: 32];
      end
      S_START: begin
        bus_en_o    = 1'b1;
        bus_we_o    = 4'b1111;
        bus_addr_o  = ADDR_CSR;
        bus_wdata_o = 32'h1;
      end
      S_POLL: begin
        bus_en_o   = 1'b1;
        bus_addr_o = ADDR_CSR;
      end
      S_CT_RD: begin
        bus_en_o   = 1'b1;
        bus_addr_o = {4'h2, beat_cnt, 2'b00};
      end
      default: ;
    endcase
  end

  assign s_ready_o     = s_ready_q;
  assign m_valid_o     = (state == S_OUT);
  assign m_data_o      = m_valid_o ? ct_q : 128'h0;
  assign busy_o        = (state != S_IDLE);
  assign err_timeout_o = err_q;

`ifdef SIMON_STREAM_PERF_EN
  logic [15:0] blk_cnt;
  logic [15:0] lat_cnt;
  logic [15:0] last_lat;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // ---- performance counters ----
  always_ff @(posedge clk) begin
    if (rst) begin
      blk_cnt  <= 16'd0;
      lat_cnt  <= 16'd0;
      last_lat <= 16'd0;
    end else begin
      if (state == S_OUT && m_ready_i) blk_cnt <= blk_cnt + 16'd1;
      if (accept) lat_cnt <= 16'd1;
      else if (state != S_IDLE && state != S_OUT) lat_cnt <= sat_inc16(lat_cnt);
      // m_valid_o rises one cycle after this edge, hence the extra count.
      if (state_nxt == S_OUT && state != S_OUT) last_lat <= sat_inc16(lat_cnt);
    end
  end

  assign blk_cnt_o  = blk_cnt;
  assign last_lat_o = last_lat;
`endif

endmodule

// File: tb/tb_simon_stream_ctrl.sv
// Directed bench for simon_stream_ctrl with a behavioural Simon 128/128 register slave.
module tb_simon_stream_ctrl;

  localparam int CORE_LAT = 6;

  localparam logic [127:0] KEY1 = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
  localparam logic [127:0] KEY2 = 128'h1f1e1d1c_1b1a1918_17161514_13121110;
  localparam logic [127:0] PT1  = 128'h63736564_20737265_6c6c6576_61727420;
  localparam logic [127:0] CT1  = 128'h49681b1e1e54fe3f_65aa832af84e0bbc;
  localparam logic [127:0] PT2  = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] PT3  = 128'hdeadbeef_01234567_89abcdef_cafef00d;
  localparam logic [127:0] PT4  = 128'h0badc0de_11111111_22222222_33333333;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] key_i;
  logic         key_load_i;
  logic         mode_i;
  logic         s_valid_i;
  logic         s_ready_o;
  logic [127:0] s_data_i;
  logic         m_valid_o;
  logic         m_ready_i;
  logic [127:0] m_data_o;
  logic         busy_o;
  logic         err_timeout_o;
  logic         bus_en_o;
  logic [3:0]   bus_we_o;
  logic [7:0]   bus_addr_o;
  logic [31:0]  bus_wdata_o;
  logic [31:0]  bus_rdata_i;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  simon_stream_ctrl dut (
    .clk(clk), .rst(rst), .key_i(key_i), .key_load_i(key_load_i), .mode_i(mode_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o),
    .busy_o(busy_o), .err_timeout_o(err_timeout_o), .bus_en_o(bus_en_o),
    .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_rdata_i(bus_rdata_i)
  );

  function automatic logic [63:0] rotl(input logic [63:0] v, input int n);
    return (v << n) | (v >> (64 - n));
  endfunction

  function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic logic [127:0] simon(input logic [127:0] key, input logic [127:0] blk,
                                         input logic enc);
    logic [63:0] k [0:67];
    logic [63:0] x, y, t;
    logic [61:0] z2;
    z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
    k[0] = key[63:0];
    k[1] = key[127:64];
    for (int i = 0; i < 66; i++) begin
      t = rotr(k[i+1], 3);
      t = t ^ rotr(t, 1);
      k[i+2] = ~k[i] ^ t ^ {63'h0, z2[61 - (i % 62)]} ^ 64'd3;
    end
    x = blk[127:64];
    y = blk[63:0];
    if (enc) begin
      for (int i = 0; i < 68; i++) begin
        t = x;
        x = y ^ ((rotl(x, 1) & rotl(x, 8)) ^ rotl(x, 2)) ^ k[i];
        y = t;
      end
    end else begin
      for (int i = 67; i >= 0; i--) begin
        t = y;
        y = x ^ ((rotl(y, 1) & rotl(y, 8)) ^ rotl(y, 2)) ^ k[i];
        x = t;
      end
    end
    return {x, y};
  endfunction

  // Register slave: one-cycle read latency, core result CORE_LAT cycles after start.
  logic [31:0]  sreg [0:15];
  logic         csr_valid = 1'b0;
  logic         hang = 1'b0;
  int           core_cnt = 0;
  logic [127:0] core_res;

  always_comb core_res = simon({sreg[7], sreg[6], sreg[5], sreg[4]},
                               {sreg[3], sreg[2], sreg[1], sreg[0]}, sreg[13][0]);

  always @(posedge clk) begin
    bus_rdata_i <= (bus_addr_o == 8'h30) ? {30'h0, csr_valid, 1'b0} : sreg[bus_addr_o[5:2]];
    if (bus_en_o && bus_we_o == 4'b1111) begin
      if (bus_addr_o == 8'h30) begin
        if (bus_wdata_o[0]) begin
          csr_valid <= 1'b0;
          core_cnt  <= CORE_LAT;
        end
      end else begin
        sreg[bus_addr_o[5:2]] <= bus_wdata_o;
      end
    end else if (core_cnt != 0) begin
      core_cnt <= core_cnt - 1;
      if (core_cnt == 1) begin
        sreg[8]   <= core_res[31:0];
        sreg[9]   <= core_res[63:32];
        sreg[10]  <= core_res[95:64];
        sreg[11]  <= core_res[127:96];
        csr_valid <= !hang;
      end
    end
  end

  typedef struct packed {
    logic [7:0]  addr;
    logic        we;
    logic [31:0] data;
  } beat_t;

  beat_t log_q[$];

  always @(negedge clk)
    if (bus_en_o) log_q.push_back({bus_addr_o, (bus_we_o == 4'b1111), bus_wdata_o});

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [127:0] k);
    key_i      = k;
    key_load_i = 1'b1;
    tick();
    key_load_i = 1'b0;
  endtask

  task automatic send_block(input logic [127:0] d, input logic m, output bit ok);
    int n = 0;
    s_data_i  = d;
    mode_i    = m;
    s_valid_i = 1'b1;
    while (!s_ready_o && n < 200) begin
      tick();
      n++;
    end
    ok = s_ready_o;
    tick();
    s_valid_i = 1'b0;
  endtask

  task automatic wait_out(output bit ok);
    int n = 0;
    while (!m_valid_o && n < 3000) begin
      tick();
      n++;
    end
    ok = m_valid_o;
  endtask

  task automatic run_block(input logic [127:0] d, input logic m,
                           output logic [127:0] r, output bit ok);
    bit ok_in, ok_out;
    send_block(d, m, ok_in);
    wait_out(ok_out);
    ok = ok_in && ok_out;
    r  = m_data_o;
    if (ok_out) begin
      m_ready_i = 1'b1;
      tick();
      m_ready_i = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_tests++;
    if ({s_ready_o, m_valid_o, busy_o, err_timeout_o, bus_en_o} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 00000",
               {s_ready_o, m_valid_o, busy_o, err_timeout_o, bus_en_o});
    end
    n_tests++;
    if ({bus_we_o, bus_addr_o, bus_wdata_o} !== 44'h0) begin
      n_fail++;
      $display("FAIL reset_bus: got we=%h addr=%h wdata=%h want all 0", bus_we_o, bus_addr_o, bus_wdata_o);
    end
    n_tests++;
    if (m_data_o !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_mdata: got %h want 0", m_data_o);
    end
    rst = 1'b0;
    tick();
    n_tests++;
    if ({s_ready_o, busy_o, err_timeout_o} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_idle_ready: got %b want 100", {s_ready_o, busy_o, err_timeout_o});
    end
  endtask

  task automatic test_encrypt();
    logic [127:0] r;
    bit ok;
    load_key(KEY1);
    log_q.delete();
    run_block(PT1, 1'b1, r, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL enc_handshake: got no result want result");
    end
    n_tests++;
    if (r !== CT1) begin
      n_fail++;
      $display("FAIL enc_ct: got %h want %h", r, CT1);
    end
    n_tests++;
    if (log_q.size() < 10) begin
      n_fail++;
      $display("FAIL enc_log_len: got %0d want >= 10", log_q.size());
    end else begin
      n_tests++;
      if (log_q[0] !== {8'h10, 1'b1, 32'h03020100}) begin
        n_fail++;
        $display("FAIL enc_key_w0: got %h want %h", log_q[0], {8'h10, 1'b1, 32'h03020100});
      end
      n_tests++;
      if (log_q[3] !== {8'h1C, 1'b1, 32'h0f0e0d0c}) begin
        n_fail++;
        $display("FAIL enc_key_w3: got %h want %h", log_q[3], {8'h1C, 1'b1, 32'h0f0e0d0c});
      end
      n_tests++;
      if (log_q[4] !== {8'h34, 1'b1, 32'h1}) begin
        n_fail++;
        $display("FAIL enc_mode_wr: got %h want %h", log_q[4], {8'h34, 1'b1, 32'h1});
      end
      n_tests++;
      if (log_q[5] !== {8'h00, 1'b1, 32'h61727420}) begin
        n_fail++;
        $display("FAIL enc_pt_w0: got %h want %h", log_q[5], {8'h00, 1'b1, 32'h61727420});
      end
      n_tests++;
      if (log_q[9] !== {8'h30, 1'b1, 32'h1}) begin
        n_fail++;
        $display("FAIL enc_start: got %h want %h", log_q[9], {8'h30, 1'b1, 32'h1});
      end
    end
  endtask

  task automatic test_same_key();
    logic [127:0] r;
    bit ok;
    int n_cfg, n_ct0, n_mode;
    log_q.delete();
    run_block(PT2, 1'b1, r, ok);
    n_tests++;
    if (!ok || r !== simon(KEY1, PT2, 1'b1)) begin
      n_fail++;
      $display("FAIL same_ct: got %h (ok=%0d) want %h", r, ok, simon(KEY1, PT2, 1'b1));
    end
    n_cfg = 0;
    n_ct0 = 0;
    foreach (log_q[i]) begin
      if (log_q[i].we && ((log_q[i].addr >= 8'h10 && log_q[i].addr <= 8'h1C) || log_q[i].addr == 8'h34))
        n_cfg++;
      if (!log_q[i].we && log_q[i].addr == 8'h20) n_ct0++;
    end
    n_tests++;
    if (n_cfg != 0) begin
      n_fail++;
      $display("FAIL same_no_cfg: got %0d key/mode writes want 0", n_cfg);
    end
    n_tests++;
    if (log_q.size() == 0 || log_q[0] !== {8'h00, 1'b1, PT2[31:0]}) begin
      n_fail++;
      $display("FAIL same_first_beat: got %h want %h", log_q.size() ? log_q[0] : '0, {8'h00, 1'b1, PT2[31:0]});
    end
    n_tests++;
    if (n_ct0 != 2) begin
      n_fail++;
      $display("FAIL same_ct_hold: got %0d beats at 0x20 want 2", n_ct0);
    end

    log_q.delete();
    run_block(CT1, 1'b0, r, ok);
    n_tests++;
    if (!ok || r !== PT1) begin
      n_fail++;
      $display("FAIL dec_pt: got %h (ok=%0d) want %h", r, ok, PT1);
    end
    n_mode = 0;
    foreach (log_q[i]) if (log_q[i].we && log_q[i].addr == 8'h34) n_mode++;
    n_tests++;
    if (n_mode != 1) begin
      n_fail++;
      $display("FAIL dec_mode_cnt: got %0d want 1", n_mode);
    end
    n_tests++;
    if (log_q.size() == 0 || log_q[0] !== {8'h34, 1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL dec_mode_wr: got %h want %h", log_q.size() ? log_q[0] : '0, {8'h34, 1'b1, 32'h0});
    end
  endtask

  task automatic test_back_pressure();
    logic [127:0] d0;
    bit ok_in, ok_out;
    int bad;
    send_block(PT3, 1'b1, ok_in);
    wait_out(ok_out);
    d0 = m_data_o;
    n_tests++;
    if (!ok_in || !ok_out || d0 !== simon(KEY1, PT3, 1'b1)) begin
      n_fail++;
      $display("FAIL bp_ct: got %h (ok=%0d%0d) want %h", d0, ok_in, ok_out, simon(KEY1, PT3, 1'b1));
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!m_valid_o || m_data_o !== d0 || s_ready_o) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL bp_hold: got %0d unstable cycles want 0", bad);
    end
    m_ready_i = 1'b1;
    n_tests++;
    if (s_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_ready_in_hs: got %b want 0", s_ready_o);
    end
    tick();
    m_ready_i = 1'b0;
    n_tests++;
    if ({s_ready_o, m_valid_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL bp_after_hs: got ready,valid=%b want 10", {s_ready_o, m_valid_o});
    end
  endtask

  task automatic test_key_load_busy();
    logic [127:0] r;
    bit ok_in, ok_out, ok;
    int n = 0;
    send_block(PT4, 1'b1, ok_in);
    while (!(bus_en_o && bus_we_o == 4'b0000 && bus_addr_o == 8'h30) && n < 100) begin
      tick();
      n++;
    end
    n_tests++;
    if (!(bus_en_o && bus_we_o == 4'b0000 && bus_addr_o == 8'h30)) begin
      n_fail++;
      $display("FAIL kl_reach_poll: got addr=%h we=%h want poll of 0x30", bus_addr_o, bus_we_o);
    end
    load_key(KEY2);
    wait_out(ok_out);
    r = m_data_o;
    n_tests++;
    if (!ok_in || !ok_out || r !== simon(KEY1, PT4, 1'b1)) begin
      n_fail++;
      $display("FAIL kl_old_key: got %h want %h", r, simon(KEY1, PT4, 1'b1));
    end
    m_ready_i = 1'b1;
    tick();
    m_ready_i = 1'b0;

    log_q.delete();
    run_block(PT4, 1'b1, r, ok);
    n_tests++;
    if (log_q.size() < 5 || log_q[0] !== {8'h10, 1'b1, 32'h13121110} ||
        log_q[3] !== {8'h1C, 1'b1, 32'h1f1e1d1c} || log_q[4].addr !== 8'h34) begin
      n_fail++;
      $display("FAIL kl_new_key_wr: got %h %h %h want %h %h addr 34",
               log_q.size() > 0 ? log_q[0] : '0, log_q.size() > 3 ? log_q[3] : '0,
               log_q.size() > 4 ? log_q[4] : '0,
               {8'h10, 1'b1, 32'h13121110}, {8'h1C, 1'b1, 32'h1f1e1d1c});
    end
    n_tests++;
    if (!ok || r !== simon(KEY2, PT4, 1'b1)) begin
      n_fail++;
      $display("FAIL kl_new_ct: got %h want %h", r, simon(KEY2, PT4, 1'b1));
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] r;
    bit ok;
    int n = 0;
    send_block(PT1, 1'b1, ok);
    while (!(bus_en_o && bus_we_o == 4'b1111 && bus_addr_o == 8'h04) && n < 100) begin
      tick();
      n++;
    end
    n_tests++;
    if (bus_addr_o !== 8'h04) begin
      n_fail++;
      $display("FAIL rm_reach_pt: got addr %h want 04", bus_addr_o);
    end
    rst = 1'b1;
    tick();
    n_tests++;
    if ({s_ready_o, m_valid_o, busy_o, err_timeout_o, bus_en_o, bus_we_o, bus_addr_o, bus_wdata_o} !== 49'h0
        || m_data_o !== 128'h0) begin
      n_fail++;
      $display("FAIL rm_outputs: got ctrl=%b addr=%h wdata=%h want all 0",
               {s_ready_o, m_valid_o, busy_o, err_timeout_o, bus_en_o}, bus_addr_o, bus_wdata_o);
    end
    rst = 1'b0;
    tick();
    load_key(KEY1);
    log_q.delete();
    run_block(PT1, 1'b1, r, ok);
    n_tests++;
    if (log_q.size() < 6 || log_q[0].addr !== 8'h10 || log_q[3].addr !== 8'h1C ||
        log_q[4].addr !== 8'h34 || log_q[5].addr !== 8'h00) begin
      n_fail++;
      $display("FAIL rm_order: got %h %h %h %h want addrs 10 1c 34 00",
               log_q.size() > 0 ? log_q[0].addr : 8'h0, log_q.size() > 3 ? log_q[3].addr : 8'h0,
               log_q.size() > 4 ? log_q[4].addr : 8'h0, log_q.size() > 5 ? log_q[5].addr : 8'h0);
    end
    n_tests++;
    if (!ok || r !== CT1) begin
      n_fail++;
      $display("FAIL rm_ct: got %h want %h", r, CT1);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int n = 0;
    int polls = 0;
    int bad = 0;
    hang = 1'b1;
    send_block(PT2, 1'b1, ok);
    while (!err_timeout_o && n < 1500) begin
      if (bus_en_o && bus_we_o == 4'b0000 && bus_addr_o == 8'h30) polls++;
      tick();
      n++;
    end
    n_tests++;
    if (err_timeout_o !== 1'b1) begin
      n_fail++;
      $display("FAIL to_err_set: got %b want 1", err_timeout_o);
    end
    n_tests++;
    if (polls != 1024) begin
      n_fail++;
      $display("FAIL to_poll_count: got %0d want 1024", polls);
    end
    s_valid_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (s_ready_o || bus_en_o || m_valid_o || !err_timeout_o) bad++;
    end
    s_valid_i = 1'b0;
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL to_sticky: got %0d bad cycles want 0", bad);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    hang = 1'b0;
    n_tests++;
    if ({err_timeout_o, s_ready_o} !== 2'b01) begin
      n_fail++;
      $display("FAIL to_rst_clear: got err,ready=%b want 01", {err_timeout_o, s_ready_o});
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) sreg[i] = 32'h0;
    bus_rdata_i = 32'h0;
    rst         = 1'b1;
    key_i       = 128'h0;
    key_load_i  = 1'b0;
    mode_i      = 1'b0;
    s_valid_i   = 1'b0;
    s_data_i    = 128'h0;
    m_ready_i   = 1'b0;
    test_reset();
    test_encrypt();
    test_same_key();
    test_back_pressure();
    test_key_load_busy();
    test_reset_mid();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
